// File: rtl/ro_puf_eval.sv
// ro_puf_eval: ring-oscillator PUF evaluator. For each response bit it
// selects the oscillator pair at (challenge + k) mod N_RO and counts rising
// edges on both banks over a programmable window. Bit k of the response is
// set when bank A counted strictly more edges than bank B.
// Optional build macro: RO_PUF_MAJORITY_EN (each bit is the majority of 3
// measurements).
// Ports:
//   clk, rst_n           clock; asynchronous active-high reset
//   start                one-cycle evaluation request (ignored while busy)
//   challenge            base oscillator index
//   window               measurement window in clk cycles (0 behaves as 1)
//   ro_a, ro_b           asynchronous oscillator banks
//   busy, done           evaluation in progress / one-cycle completion pulse
//   response             last completed response
//   sat                  a counter saturated during the last evaluation
module ro_puf_eval #(
  parameter int unsigned N_RO      = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RESP_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [$clog2(N_RO)-1:0]   challenge,
  input  logic [15:0]               window,
  input  logic [N_RO-1:0]           ro_a,
  input  logic [N_RO-1:0]           ro_b,
  output logic                      busy,
  output logic                      done,
  output logic [RESP_BITS-1:0]      response,
  output logic                      sat
);

  localparam int unsigned IW = $clog2(N_RO);
  localparam int unsigned KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, LOAD, CLEAR, COUNT, DRAIN, COMPARE, NEXT, DONE
  } state_t;

  state_t                state, state_d;
  logic [IW-1:0]         chal_q;
  logic [15:0]           win_q;
  logic [15:0]           timer;
  logic [KW-1:0]         bit_k;
  logic [IW-1:0]         idx;
  logic                  a_s1, a_s2, a_s3;
  logic                  b_s1, b_s2, b_s3;
  logic [CNT_W-1:0]      cnt_a, cnt_b;
  logic [RESP_BITS-1:0]  resp_acc;
  logic                  sat_acc;
  logic                  accept_c, count_en_c, cmp_c, bit_val_c;
  logic                  last_bit_c, last_pass_c;
`ifdef RO_PUF_MAJORITY_EN
  logic [1:0]            pass_q;
  logic [1:0]            votes;
`endif

  // Pair index wraps naturally because N_RO is a power of two.
  assign idx = chal_q + IW'(bit_k);

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d     = state;
    accept_c    = 1'b0;
    count_en_c  = (state == COUNT) || (state == DRAIN);
    cmp_c       = (cnt_a > cnt_b);
    last_bit_c  = (bit_k == KW'(RESP_BITS - 1));
`ifdef RO_PUF_MAJORITY_EN
    last_pass_c = (pass_q == 2'd2);
    bit_val_c   = (votes[0] & votes[1]) | (votes[0] & cmp_c) | (votes[1] & cmp_c);
`else
    last_pass_c = 1'b1;
    bit_val_c   = cmp_c;
`endif
    case (state)
      IDLE: begin
        // done is high only in the cycle right after DONE; a start there is dropped
        if (start && !done) begin
          accept_c = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD:    state_d = CLEAR;
      CLEAR:   state_d = COUNT;
      COUNT:   if (timer == win_q - 16'd1) state_d = DRAIN;
      DRAIN:   if (timer == 16'd2) state_d = COMPARE;
      COMPARE: state_d = NEXT;
      NEXT: begin
        if (last_pass_c && last_bit_c) state_d = DONE;
        else                           state_d = CLEAR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: synchronizers, counters, timers and result registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      chal_q   <= '0;
      win_q    <= 16'd1;
      timer    <= '0;
      bit_k    <= '0;
      a_s1     <= 1'b0;
      a_s2     <= 1'b0;
      a_s3     <= 1'b0;
      b_s1     <= 1'b0;
      b_s2     <= 1'b0;
      b_s3     <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      resp_acc <= '0;
      sat_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      sat      <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
      pass_q   <= '0;
      votes    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept_c) busy <= 1'b1;

      // A freshly cleared pipeline prevents stale samples of the previous
      // pair from appearing as an edge on the new pair.
      if (state == CLEAR) begin
        {a_s1, a_s2, a_s3} <= 3'b000;
        {b_s1, b_s2, b_s3} <= 3'b000;
      end else begin
        a_s1 <= ro_a[idx];
        a_s2 <= a_s1;
        a_s3 <= a_s2;
        b_s1 <= ro_b[idx];
        b_s2 <= b_s1;
        b_s3 <= b_s2;
      end

      case (state)
        LOAD: begin
          chal_q   <= challenge;
          win_q    <= (window == 16'd0) ? 16'd1 : window;
          bit_k    <= '0;
          resp_acc <= '0;
          sat_acc  <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
          pass_q   <= '0;
          votes    <= '0;
`endif
        end
        CLEAR: begin
          cnt_a <= '0;
          cnt_b <= '0;
          timer <= '0;
        end
        COUNT: begin
          if (state_d == DRAIN) timer <= '0;
          else                  timer <= timer + 16'd1;
        end
        DRAIN: timer <= timer + 16'd1;
        COMPARE: begin
          if ((cnt_a == CNT_MAX) || (cnt_b == CNT_MAX)) sat_acc <= 1'b1;
`ifdef RO_PUF_MAJORITY_EN
          if (pass_q == 2'd0) votes[0] <= cmp_c;
          if (pass_q == 2'd1) votes[1] <= cmp_c;
`endif
          if (last_pass_c) resp_acc <= resp_acc | (RESP_BITS'(bit_val_c) << bit_k);
        end
        NEXT: begin
`ifdef RO_PUF_MAJORITY_EN
          if (!last_pass_c) pass_q <= pass_q + 2'd1;
          else              pass_q <= '0;
`endif
          if (last_pass_c && !last_bit_c) bit_k <= bit_k + KW'(1);
        end
        DONE: begin
          response <= resp_acc;
          sat      <= sat_acc;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase

      // Saturating edge counters, live through COUNT and DRAIN
      if (count_en_c) begin
        if (a_s2 && !a_s3 && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_W'(1);
        if (b_s2 && !b_s3 && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_W'(1);
      end
    end
  end

endmodule
